// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/redirect controller.
package pipe_ctrl_pkg;

  localparam logic [1:0] PC_SEL_ADDER = 2'b00;
  localparam logic [1:0] PC_SEL_ID    = 2'b01;
  localparam logic [1:0] PC_SEL_HOLD  = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/load_use_det.sv
// Load-use hazard compare: the ID instruction reads a register still being loaded by EXE.
module load_use_det (
  input  logic       exe_is_load,
  input  logic [4:0] exe_wb_addr,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  output logic       lu
);

  logic rs_hit, rt_hit;

  assign rs_hit = id_rs_used & (id_rs == exe_wb_addr);
  assign rt_hit = id_rt_used & (id_rt == exe_wb_addr);
  // $zero is never a real dependency
  assign lu     = exe_is_load & (exe_wb_addr != 5'd0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/redirect controller: one-bubble load-use stalls and fixed-latency MDU busy sequencing.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       id_branch_taken,
  input  logic       id_is_mdu,
  input  logic       exe_is_load,
  input  logic [4:0] exe_wb_addr,
  output logic [1:0] if_pc_sel,
  output logic       if_id_en,
  output logic       id_exe_flush,
  output logic       mdu_start,
  output logic       mdu_busy
);

  localparam int unsigned CntW = $clog2(MDU_LAT + 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            lu;
  logic            mdu_go;
  logic            stall;

  load_use_det u_load_use_det (
    .exe_is_load (exe_is_load),
    .exe_wb_addr (exe_wb_addr),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .lu          (lu)
  );

  assign mdu_go = id_is_mdu & ~lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mdu_go) begin
            state_q <= ST_BUSY;
            cnt_q   <= CntW'(MDU_LAT - 1);
          end
        end
        ST_BUSY: begin
          // cnt == 0 is the release cycle; the MDU instruction leaves ID now
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    mdu_start    = (state_q == ST_RUN) & mdu_go;
    mdu_busy     = (state_q == ST_BUSY);
    stall        = lu | mdu_start | (mdu_busy & (cnt_q != '0));
    if_id_en     = ~stall;
    id_exe_flush = stall;
    if (stall) begin
      if_pc_sel = PC_SEL_HOLD;
    end else if (id_branch_taken) begin
      if_pc_sel = PC_SEL_ID;
    end else begin
      if_pc_sel = PC_SEL_ADDER;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: three latencies driven in parallel against a cycle-number model.
module tb_pipe_stall_ctrl;

  localparam int NDUT = 3;
  localparam int LAT[NDUT] = '{32, 4, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, exe_wb_addr = '0;
  logic       id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic       id_branch_taken = 1'b0, id_is_mdu = 1'b0, exe_is_load = 1'b0;

  logic [1:0] sel_v [NDUT];
  logic [NDUT-1:0] en_v, flush_v, start_v, busy_v;

  int checks = 0;
  int errors = 0;

  // Model: an MDU issued at cycle t keeps the DUT busy for cycles t+1..t+LAT, stalled up to t+LAT-1.
  int cyc = 0;
  int iss [NDUT];
  bit have [NDUT];
  bit start_exp [NDUT];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MDU_LAT(32)) u_dut32 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_branch_taken(id_branch_taken), .id_is_mdu(id_is_mdu),
    .exe_is_load(exe_is_load), .exe_wb_addr(exe_wb_addr), .if_pc_sel(sel_v[0]),
    .if_id_en(en_v[0]), .id_exe_flush(flush_v[0]), .mdu_start(start_v[0]), .mdu_busy(busy_v[0])
  );

  pipe_stall_ctrl #(.MDU_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_branch_taken(id_branch_taken), .id_is_mdu(id_is_mdu),
    .exe_is_load(exe_is_load), .exe_wb_addr(exe_wb_addr), .if_pc_sel(sel_v[1]),
    .if_id_en(en_v[1]), .id_exe_flush(flush_v[1]), .mdu_start(start_v[1]), .mdu_busy(busy_v[1])
  );

  pipe_stall_ctrl #(.MDU_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_branch_taken(id_branch_taken), .id_is_mdu(id_is_mdu),
    .exe_is_load(exe_is_load), .exe_wb_addr(exe_wb_addr), .if_pc_sel(sel_v[2]),
    .if_id_en(en_v[2]), .id_exe_flush(flush_v[2]), .mdu_start(start_v[2]), .mdu_busy(busy_v[2])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Compare process: evaluated on the falling edge, inputs stable since posedge+1.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NDUT; k++) start_exp[k] = 1'b0;
    end else begin
      bit lu_m, busy_m, bstall_m, stall_m;
      int el, sel_m;
      lu_m = exe_is_load && (exe_wb_addr != 0) &&
             ((id_rs_used && id_rs == exe_wb_addr) || (id_rt_used && id_rt == exe_wb_addr));
      for (int k = 0; k < NDUT; k++) begin
        el = cyc - iss[k];
        busy_m   = have[k] && el >= 1 && el <= LAT[k];
        bstall_m = have[k] && el >= 1 && el <= LAT[k] - 1;
        start_exp[k] = !busy_m && id_is_mdu && !lu_m;
        stall_m = lu_m || start_exp[k] || bstall_m;
        sel_m = stall_m ? 2 : (id_branch_taken ? 1 : 0);
        chk($sformatf("model_lat%0d_start", LAT[k]), int'(start_v[k]), int'(start_exp[k]));
        chk($sformatf("model_lat%0d_busy", LAT[k]), int'(busy_v[k]), int'(busy_m));
        chk($sformatf("model_lat%0d_en", LAT[k]), int'(en_v[k]), int'(!stall_m));
        chk($sformatf("model_lat%0d_flush", LAT[k]), int'(flush_v[k]), int'(stall_m));
        chk($sformatf("model_lat%0d_sel", LAT[k]), int'(sel_v[k]), sel_m);
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        have[k] = 1'b0;
      end else if (start_exp[k]) begin
        have[k] = 1'b1;
        iss[k]  = cyc;
      end
    end
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_branch_taken = 1'b0; id_is_mdu = 1'b0; exe_is_load = 1'b0; exe_wb_addr = '0;
  endtask

  initial begin
    // Expected values for cycles T..T+5 with id_is_mdu held and a branch in ID from T+1.
    int exp_start4[6] = '{1, 0, 0, 0, 0, 1};
    int exp_en4[6]    = '{0, 0, 0, 0, 1, 0};
    int exp_busy4[6]  = '{0, 1, 1, 1, 1, 0};
    int exp_sel4[6]   = '{2, 2, 2, 2, 1, 2};
    int exp_start1[6] = '{1, 0, 1, 0, 1, 0};
    int exp_busy1[6]  = '{0, 1, 0, 1, 0, 1};
    int exp_sel1[6]   = '{2, 1, 2, 1, 2, 1};

    for (int k = 0; k < NDUT; k++) begin
      have[k] = 1'b0; iss[k] = 0; start_exp[k] = 1'b0;
    end
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    at_neg();
    chk("reset_sel", int'(sel_v[0]), 0);
    chk("reset_en", int'(en_v[0]), 1);
    chk("reset_flush", int'(flush_v[0]), 0);
    chk("reset_busy", int'(busy_v[0]), 0);
    chk("reset_start", int'(start_v[0]), 0);

    // Load-use on rs: exactly one bubble.
    next_cycle();
    exe_is_load = 1'b1; exe_wb_addr = 5'd8; id_rs = 5'd8; id_rs_used = 1'b1;
    at_neg();
    chk("lu_sel", int'(sel_v[0]), 2);
    chk("lu_en", int'(en_v[0]), 0);
    chk("lu_flush", int'(flush_v[0]), 1);
    next_cycle();
    exe_is_load = 1'b0;
    at_neg();
    chk("lu_after_en", int'(en_v[0]), 1);
    chk("lu_after_sel", int'(sel_v[0]), 0);

    // Load into $zero never stalls.
    next_cycle();
    exe_is_load = 1'b1; exe_wb_addr = 5'd0; id_rs = 5'd0; id_rs_used = 1'b1;
    at_neg();
    chk("lu_zero_en", int'(en_v[0]), 1);
    chk("lu_zero_sel", int'(sel_v[0]), 0);

    next_cycle();
    set_idle();
    id_branch_taken = 1'b1;
    at_neg();
    chk("branch_sel", int'(sel_v[0]), 1);

    // Load-use and MDU together: lu wins, MDU starts one cycle later (cycle T).
    next_cycle();
    set_idle();
    exe_is_load = 1'b1; exe_wb_addr = 5'd9; id_rt = 5'd9; id_rt_used = 1'b1; id_is_mdu = 1'b1;
    at_neg();
    chk("prio_no_start", int'(start_v[0]), 0);
    chk("prio_hold", int'(sel_v[0]), 2);
    next_cycle();
    exe_is_load = 1'b0;
    at_neg();
    chk("prio_start32", int'(start_v[0]), 1);
    chk("mdu4_start_t0", int'(start_v[1]), exp_start4[0]);
    chk("mdu1_start_t0", int'(start_v[2]), exp_start1[0]);

    for (int i = 1; i < 6; i++) begin
      next_cycle();
      id_branch_taken = 1'b1;
      at_neg();
      chk($sformatf("mdu4_start_t%0d", i), int'(start_v[1]), exp_start4[i]);
      chk($sformatf("mdu4_en_t%0d", i), int'(en_v[1]), exp_en4[i]);
      chk($sformatf("mdu4_busy_t%0d", i), int'(busy_v[1]), exp_busy4[i]);
      chk($sformatf("mdu4_sel_t%0d", i), int'(sel_v[1]), exp_sel4[i]);
      chk($sformatf("mdu1_start_t%0d", i), int'(start_v[2]), exp_start1[i]);
      chk($sformatf("mdu1_busy_t%0d", i), int'(busy_v[2]), exp_busy1[i]);
      chk($sformatf("mdu1_sel_t%0d", i), int'(sel_v[2]), exp_sel1[i]);
      chk($sformatf("mdu32_sel_t%0d", i), int'(sel_v[0]), 2);
    end

    // Run the 32-cycle MDU to cycle T+22 (count 10), then reset asynchronously mid-cycle.
    next_cycle();
    set_idle();
    repeat (16) next_cycle();
    at_neg();
    chk("busy32_before_rst", int'(busy_v[0]), 1);
    chk("stall32_before_rst", int'(en_v[0]), 0);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy_v[0]), 0);
    chk("async_rst_sel", int'(sel_v[0]), 0);
    chk("async_rst_en", int'(en_v[0]), 1);
    next_cycle();
    rst = 1'b0;
    at_neg();
    chk("post_rst_start", int'(start_v[0]), 0);
    chk("post_rst_busy", int'(busy_v[0]), 0);
    chk("post_rst_sel", int'(sel_v[0]), 0);

    // Randomised traffic, small register range so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      exe_wb_addr     = 5'($urandom_range(0, 3));
      id_rs_used      = 1'($urandom_range(0, 1));
      id_rt_used      = 1'($urandom_range(0, 1));
      exe_is_load     = ($urandom_range(0, 9) < 3);
      id_is_mdu       = ($urandom_range(0, 9) < 2);
      id_branch_taken = ($urandom_range(0, 9) < 3);
    end

    next_cycle();
    set_idle();
    at_neg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall/redirect controller for the 5-stage CPU. Drives the IF PC select (next PC, ID redirect, hold), the IF/ID register enable and the ID/EXE bubble. It detects load-use hazards and sequences a fixed-latency multiply/divide unit (MDU) busy period. Branch and jump targets are resolved in ID, and the delay slot always executes, so this block never flushes IF.

## Interface
- `MDU_LAT`, default 32: total cycles an MDU instruction is held in ID; legal range ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID.
- `id_rs_used`, `id_rt_used`  in  1 each  the ID instruction actually reads rs/rt.
- `id_branch_taken`  in  1  the ID instruction redirects the PC (taken branch, j, jal, jr, jalr).
- `id_is_mdu`  in  1  the ID instruction is mult/multu/div/divu.
- `exe_is_load`  in  1  the EXE instruction is a load.
- `exe_wb_addr`  in  5  destination register of the EXE instruction.
- `if_pc_sel`  out  2  `00` = PC+4, `01` = ID target, `10` = hold current PC.
- `if_id_en`  out  1  IF/ID pipeline register write enable.
- `id_exe_flush`  out  1  load a bubble (NOP) into ID/EXE.
- `mdu_start`  out  1  one-cycle start pulse to the MDU.
- `mdu_busy`  out  1  high while in state BUSY.

## Operation
- Load-use hazard, combinational:
  - `lu = exe_is_load & (exe_wb_addr != 0) & ((id_rs_used & id_rs == exe_wb_addr) | (id_rt_used & id_rt == exe_wb_addr))`.
  - One bubble only; MEM-stage forwarding covers the following cycle.
- FSM with two states:
  - RUN → BUSY when `mdu_go = id_is_mdu & ~lu`. Load counter `cnt <= MDU_LAT-1`.
  - BUSY, `cnt != 0`: `cnt` decrements by 1 and the state stays BUSY.
  - BUSY, `cnt == 0`: release cycle; next state RUN.
- `mdu_start = (state == RUN) & mdu_go`.
- `stall = lu | mdu_start | (state == BUSY & cnt != 0)`.
- Outputs:
  - `if_id_en = ~stall`.
  - `id_exe_flush = stall`.
  - `if_pc_sel = stall ? 10 : id_branch_taken ? 01 : 00`.
- Counter width is `$clog2(MDU_LAT+1)`, unsigned, and never wraps (decrement is gated at 0).

## Timing
- Reset values: state RUN, `cnt` 0, `mdu_busy` 0, `mdu_start` 0.
  - With idle inputs: `if_pc_sel` 00, `if_id_en` 1, `id_exe_flush` 0.
- Only `state` and `cnt` are registered. All other outputs are combinational from the registered state and the current inputs.
- Load-use: stall for exactly 1 cycle, then the ID instruction advances.
- MDU issued in cycle T:
  - Stalled in cycles T … T+MDU_LAT-1.
  - Advances in cycle T+MDU_LAT, the release cycle. `id_is_mdu` is still high then, but no restart occurs because the state is BUSY.
- Back-to-back MDU instructions: the second starts in the cycle after release.
- Simultaneous events:
  - Load-use and MDU in ID: `lu` wins; `mdu_start` follows one cycle later.
  - Branch while stalled: hold (`10`) wins. The redirect is issued in the first unstalled cycle, because the branch is still in ID.
- `MDU_LAT = 1`: one stall cycle (T), with release at T+1.
- Reset asserted mid-BUSY: state goes to RUN and `cnt` to 0 immediately, without waiting for a clock edge. No `mdu_start` is generated by reset.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - PC select constants `PC_SEL_ADDER = 2'b00`, `PC_SEL_ID = 2'b01`, `PC_SEL_HOLD = 2'b10`.
  - State encoding `ST_RUN`, `ST_BUSY`.
- One sub-module, `load_use_det`: the purely combinational hazard compare producing `lu`.
- Top level holds the FSM, the counter and the output logic.

## Test plan
- **Reset:** assert `rst` async mid-cycle during BUSY with `cnt` = 10 → `mdu_busy` = 0 and `if_pc_sel` = 00 immediately; after release, idle outputs with no `mdu_start`.
- **Load-use:** `exe_is_load` = 1, `exe_wb_addr` = 8, `id_rs` = 8, `id_rs_used` = 1 → one cycle of `if_pc_sel` = 10, `if_id_en` = 0, `id_exe_flush` = 1.
  - Same stimulus with `exe_wb_addr` = 0 → no stall.
- **MDU, `MDU_LAT` = 4:** `id_is_mdu` held high → `mdu_start` pulse at T, stall at T..T+3, release at T+4, no second pulse.
  - A second MDU instruction then pulses at T+5.
- **Branch:** `id_branch_taken` = 1 with no hazard → `if_pc_sel` = 01.
  - Branch during BUSY → 10 until release, then 01 in the release cycle.
- **Priority:** `lu` and `id_is_mdu` in the same cycle → no `mdu_start` that cycle, pulse on the next.
- **`MDU_LAT` = 1:** `mdu_start` with one stall cycle; release at T+1 and `mdu_busy` high for that single cycle.
